// File: rtl/psram_xfer_seq.sv
// PSRAM transaction sequencer: shifts one latched command/address/dummy/data
// transfer onto the pads in SPI or QPI mode, then holds CE# high before completing.
module psram_xfer_seq #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    qpi_i,
    input  logic                    wr_i,
    input  logic [1:0]              div_i,
    input  logic [7:0]              cmd_i,
    input  logic [23:0]             addr_i,
    input  logic [7:0]              wait_i,
    input  logic [1:0]              len_i,
    input  logic [8*DATA_BYTES-1:0] wdata_i,
    input  logic [3:0]              io_in_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [8*DATA_BYTES-1:0] rdata_o,
    output logic                    sck_o,
    output logic                    ce_n_o,
    output logic [3:0]              io_out_o,
    output logic [3:0]              io_oe_o
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int TXW = 32 + DW;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_CSH} state_t;

    state_t          state_q;
    logic            qpi_q, wr_q;
    logic [1:0]      div_q, len_q, hcnt_q;
    logic [7:0]      wait_q, pcnt_q;
    logic [TXW-1:0]  tx_q;
    logic [DW-1:0]   rx_q, rdata_q;
    logic            sck_q, ce_n_q, busy_q, done_q;
    logic [3:0]      io_out_q, io_oe_q;

    logic [TXW-1:0]  tx_load, tx_shift;
    logic [DW-1:0]   rx_shift, rdata_asm;
    logic [7:0]      data_cnt;

    function automatic logic [3:0] lead_bits(input logic [TXW-1:0] tx, input logic qpi);
        return qpi ? tx[TXW-1 -: 4] : {3'b000, tx[TXW-1]};
    endfunction

    // Outgoing stream: opcode, address, then data byte 0 first, each MSB first.
    always_comb begin
        tx_load = '0;
        tx_load[TXW-1 -: 32] = {cmd_i, addr_i};
        for (int k = 0; k < DATA_BYTES; k++) begin
            tx_load[DW-1-8*k -: 8] = wdata_i[8*k +: 8];
        end
        tx_shift = qpi_q ? (tx_q << 4) : (tx_q << 1);
        rx_shift = qpi_q ? {rx_q[DW-5:0], io_in_i} : {rx_q[DW-2:0], io_in_i[1]};
        data_cnt = qpi_q ? {5'b00000, len_q, 1'b1} : {3'b000, len_q, 3'b111};
    end

    // The first received byte sits highest in rx_q; map it back to lane 0.
    always_comb begin
        rdata_asm = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (k <= int'(len_q)) begin
                rdata_asm[8*k +: 8] = rx_q[8*(int'(len_q) - k) +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            qpi_q    <= 1'b0;
            wr_q     <= 1'b0;
            div_q    <= '0;
            len_q    <= '0;
            wait_q   <= '0;
            hcnt_q   <= '0;
            pcnt_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            sck_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            io_out_q <= '0;
            io_oe_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q  <= S_CMD;
                        qpi_q    <= qpi_i;
                        wr_q     <= wr_i;
                        div_q    <= div_i;
                        len_q    <= len_i;
                        wait_q   <= wait_i;
                        hcnt_q   <= div_i;
                        pcnt_q   <= qpi_i ? 8'd1 : 8'd7;
                        tx_q     <= tx_load;
                        rx_q     <= '0;
                        sck_q    <= 1'b0;
                        ce_n_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        io_oe_q  <= qpi_i ? 4'hF : 4'h1;
                        io_out_q <= lead_bits(tx_load, qpi_i);
                    end
                end
                S_CMD, S_ADDR, S_WAIT, S_DATA: begin
                    if (hcnt_q != 2'd0) begin
                        hcnt_q <= hcnt_q - 2'd1;
                    end else begin
                        hcnt_q <= div_q;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state_q == S_DATA && !wr_q) begin
                                rx_q <= rx_shift;
                            end
                        end else begin
                            // Falling SCK: launch the next unit, possibly in the next phase.
                            sck_q <= 1'b0;
                            if (state_q != S_WAIT) begin
                                tx_q <= tx_shift;
                            end
                            if (pcnt_q != 8'd0) begin
                                pcnt_q <= pcnt_q - 8'd1;
                                if (io_oe_q != 4'h0) begin
                                    io_out_q <= lead_bits(tx_shift, qpi_q);
                                end
                            end else begin
                                case (state_q)
                                    S_CMD: begin
                                        state_q  <= S_ADDR;
                                        pcnt_q   <= qpi_q ? 8'd5 : 8'd23;
                                        io_out_q <= lead_bits(tx_shift, qpi_q);
                                    end
                                    S_ADDR: begin
                                        if (!wr_q && wait_q != 8'd0) begin
                                            state_q  <= S_WAIT;
                                            pcnt_q   <= wait_q - 8'd1;
                                            io_oe_q  <= '0;
                                            io_out_q <= '0;
                                        end else begin
                                            state_q <= S_DATA;
                                            pcnt_q  <= data_cnt;
                                            if (wr_q) begin
                                                io_out_q <= lead_bits(tx_shift, qpi_q);
                                            end else begin
                                                io_oe_q  <= '0;
                                                io_out_q <= '0;
                                            end
                                        end
                                    end
                                    S_WAIT: begin
                                        state_q <= S_DATA;
                                        pcnt_q  <= data_cnt;
                                    end
                                    default: begin
                                        state_q  <= S_CSH;
                                        hcnt_q   <= 2'd1;
                                        ce_n_q   <= 1'b1;
                                        io_oe_q  <= '0;
                                        io_out_q <= '0;
                                    end
                                endcase
                            end
                        end
                    end
                end
                S_CSH: begin
                    if (hcnt_q != 2'd0) begin
                        hcnt_q <= hcnt_q - 2'd1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= rdata_asm;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign sck_o    = sck_q;
    assign ce_n_o   = ce_n_q;
    assign io_out_o = io_out_q;
    assign io_oe_o  = io_oe_q;

endmodule

// File: tb/tb_psram_xfer_seq.sv
// Scoreboard bench for psram_xfer_seq: transactions are queued when issued and a
// per-cycle monitor compares pins, done and read data against a timing/bit model.
module tb_psram_xfer_seq;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, qpi = 1'b0, wr = 1'b0;
    logic [1:0]  div = '0, len = '0;
    logic [7:0]  cmd = '0, wt = '0;
    logic [23:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  io_in = '0;
    logic        busy, done, sck, ce_n;
    logic [31:0] rdata;
    logic [3:0]  io_out, io_oe;

    psram_xfer_seq #(.DATA_BYTES(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .qpi_i(qpi), .wr_i(wr),
        .div_i(div), .cmd_i(cmd), .addr_i(addr), .wait_i(wt), .len_i(len),
        .wdata_i(wdata), .io_in_i(io_in), .busy_o(busy), .done_o(done),
        .rdata_o(rdata), .sck_o(sck), .ce_n_o(ce_n), .io_out_o(io_out), .io_oe_o(io_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0;

    typedef struct {
        int          c0;
        bit          qpi;
        bit          wr;
        int          h;
        int          n;
        int          wt;
        int          len;
        logic [7:0]  cmd;
        logic [23:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } txn_t;

    txn_t        q[$];
    int          free_cyc = 0;
    int          last_c0 = 0;
    logic [31:0] exp_rdata = '0;

    function automatic int wbits(input txn_t t);
        return t.qpi ? 4 : 1;
    endfunction

    // Unit idx (MSB first) of an nbits-wide field, w bits per unit.
    function automatic logic [3:0] get_unit(input logic [31:0] val, input int nbits, input int w, input int idx);
        logic [31:0] x;
        x = val >> (nbits - w * (idx + 1));
        return (w == 4) ? x[3:0] : {3'b000, x[0]};
    endfunction

    // 0 = cmd, 1 = addr, 2 = dummy, 3 = data
    function automatic int phase_of(input txn_t t, input int s);
        int w;
        w = wbits(t);
        if (s < 8 / w) return 0;
        if (s < 32 / w) return 1;
        if (s < 32 / w + t.wt) return 2;
        return 3;
    endfunction

    function automatic logic [3:0] exp_oe(input txn_t t, input int s);
        int p;
        p = phase_of(t, s);
        if (p == 0 || p == 1 || (p == 3 && t.wr)) return t.qpi ? 4'hF : 4'h1;
        return 4'h0;
    endfunction

    function automatic logic [3:0] data_unit(input txn_t t, input logic [31:0] word, input int s);
        int w, d, upb;
        w   = wbits(t);
        upb = 8 / w;
        d   = s - 32 / w - t.wt;
        return get_unit((word >> (8 * (d / upb))) & 32'hFF, 8, w, d % upb);
    endfunction

    function automatic logic [3:0] exp_out(input txn_t t, input int s);
        int w, p;
        w = wbits(t);
        p = phase_of(t, s);
        if (p == 0) return get_unit({24'h0, t.cmd}, 8, w, s);
        if (p == 1) return get_unit({8'h0, t.addr}, 24, w, s - 8 / w);
        if (p == 3 && t.wr) return data_unit(t, t.wd, s);
        return 4'h0;
    endfunction

    function automatic logic [31:0] byte_mask(input int l);
        return (l == 3) ? 32'hFFFF_FFFF : ((32'h1 << (8 * (l + 1))) - 32'h1);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; start is held for exactly one cycle.
    task automatic issue(input bit q_, input bit wr_, input logic [1:0] div_, input logic [7:0] cmd_,
                         input logic [23:0] a_, input logic [7:0] wt_, input logic [1:0] len_,
                         input logic [31:0] wd_, input logic [31:0] rd_);
        txn_t t;
        int   w;
        t.c0  = cyc;
        t.qpi = q_;
        t.wr  = wr_;
        t.h   = int'(div_) + 1;
        t.wt  = wr_ ? 0 : int'(wt_);
        t.len = int'(len_);
        t.cmd = cmd_;
        t.addr = a_;
        t.wd  = wd_;
        t.rd  = rd_;
        w     = q_ ? 4 : 1;
        t.n   = 32 / w + t.wt + 8 * (t.len + 1) / w;
        if (cyc >= free_cyc) begin
            q.push_back(t);
            free_cyc = cyc + 2 * t.n * t.h + 3;
            last_c0  = cyc;
        end
        qpi = q_; wr = wr_; div = div_; cmd = cmd_; addr = a_; wt = wt_; len = len_; wdata = wd_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        qpi = 1'($urandom); wr = 1'($urandom); div = 2'($urandom); cmd = 8'($urandom);
        addr = 24'($urandom); wt = 8'($urandom); len = 2'($urandom); wdata = $urandom;
    endtask

    task automatic rand_txn();
        issue(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 24'($urandom),
              8'($urandom_range(0, 12)), 2'($urandom), $urandom, $urandom);
    endtask

    // Monitor / scoreboard and PSRAM read-data model
    txn_t       mt;
    int         rel, per, last, s;
    bit         popit;
    logic       e_ce, e_sck, e_busy, e_done;
    logic [3:0] e_oe, e_out, io_drv;

    always @(negedge clk) begin
        if (rst) begin
            tests++;
            if (ce_n !== 1'b1 || sck !== 1'b0 || io_oe !== 4'h0 || io_out !== 4'h0 ||
                busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
                fails++;
                $display("FAIL reset cyc=%0d got ce_n=%b sck=%b oe=%h out=%h busy=%b done=%b rdata=%h, want 1 0 0 0 0 0 0",
                         cyc, ce_n, sck, io_oe, io_out, busy, done, rdata);
            end
            q.delete();
            exp_rdata = '0;
            io_in = 4'($urandom);
        end else begin
            e_ce = 1'b1; e_sck = 1'b0; e_oe = 4'h0; e_out = 4'h0; e_busy = 1'b0; e_done = 1'b0;
            popit = 1'b0;
            io_drv = 4'($urandom);
            rel = 0;
            if (q.size() > 0) begin
                mt   = q[0];
                rel  = cyc - mt.c0;
                per  = 2 * mt.h;
                last = mt.n * per;
                if (rel >= 1 && rel <= last) begin
                    s      = (rel - 1) / per;
                    e_ce   = 1'b0;
                    e_busy = 1'b1;
                    e_sck  = 1'(((rel - 1) / mt.h) % 2);
                    e_oe   = exp_oe(mt, s);
                    e_out  = exp_out(mt, s);
                    if (!mt.wr && phase_of(mt, s) == 3) begin
                        if (mt.qpi) io_drv = data_unit(mt, mt.rd, s);
                        else        io_drv[1] = data_unit(mt, mt.rd, s)[0];
                    end
                end else if (rel == last + 1 || rel == last + 2) begin
                    e_busy = 1'b1;
                end else if (rel == last + 3) begin
                    e_done = 1'b1;
                    popit  = 1'b1;
                    if (!mt.wr) exp_rdata = mt.rd & byte_mask(mt.len);
                end
            end
            tests++;
            if (ce_n !== e_ce || sck !== e_sck || io_oe !== e_oe || io_out !== e_out ||
                busy !== e_busy || done !== e_done) begin
                fails++;
                $display("FAIL pins cyc=%0d rel=%0d got ce_n=%b sck=%b oe=%h out=%h busy=%b done=%b want ce_n=%b sck=%b oe=%h out=%h busy=%b done=%b",
                         cyc, rel, ce_n, sck, io_oe, io_out, busy, done, e_ce, e_sck, e_oe, e_out, e_busy, e_done);
            end
            tests++;
            if (rdata !== exp_rdata) begin
                fails++;
                $display("FAIL rdata cyc=%0d got %h want %h", cyc, rdata, exp_rdata);
            end
            if (popit) void'(q.pop_front());
            io_in = io_drv;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of the address phase
        issue(1'b0, 1'b0, 2'd0, 8'h0B, 24'hABCDEF, 8'd4, 2'd2, 32'h0, 32'h11223344);
        wait_until(last_c0 + 30);
        rst = 1'b1;
        free_cyc = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end

        // QPI write
        issue(1'b1, 1'b1, 2'd0, 8'h38, 24'h123456, 8'd0, 2'd3, 32'hDDCCBBAA, 32'h0);
        wait_until(free_cyc + 2);

        // SPI read with 8 dummy cycles returning 0xA5
        issue(1'b0, 1'b0, 2'd1, 8'h0B, 24'h00F0F0, 8'd8, 2'd0, 32'h0, {24'($urandom), 8'hA5});
        wait_until(free_cyc + 1);

        // QPI read, no dummy cycles, nibbles 1,2,3,4
        issue(1'b1, 1'b0, 2'd0, 8'hEB, 24'h000100, 8'd0, 2'd1, 32'h0, {16'($urandom), 16'h3412});
        wait_until(free_cyc + 3);

        // Start pulse while busy must be dropped
        issue(1'b0, 1'b1, 2'd2, 8'h02, 24'h654321, 8'd0, 2'd1, 32'h0000BEEF, 32'h0);
        wait_until(last_c0 + 40);
        issue(1'b1, 1'b0, 2'd0, 8'hFF, 24'hFFFFFF, 8'd3, 2'd3, 32'hFFFFFFFF, 32'h0);
        wait_until(free_cyc);

        // Back-to-back: next start in the done cycle
        issue(1'b1, 1'b0, 2'd1, 8'hEB, 24'h0A0B0C, 8'd6, 2'd2, 32'h0, 32'h00C0FFEE);
        wait_until(free_cyc);
        issue(1'b0, 1'b1, 2'd0, 8'h02, 24'h102030, 8'd0, 2'd0, 32'h0000005A, 32'h0);
        wait_until(free_cyc + 2);

        for (int i = 0; i < 30; i++) begin
            rand_txn();
            if ($urandom_range(0, 3) == 0) begin
                wait_until(last_c0 + int'($urandom_range(1, 20)));
                rand_txn();
            end
            wait_until(free_cyc + int'($urandom_range(0, 3)));
        end

        wait_until(free_cyc + 5);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending got %0d outstanding transactions want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
